lsio_timer_alarm: RTL
=====================

# lsio_timer_alarm

Multi-channel alarm scheduler layered on the low-speed-IO millisecond timer. Consumes the timer's free-running millisecond count and one-ms tick, holds per-channel compare and period registers behind a simple single-cycle register bus, and raises pending bits and a level interrupt when a channel's compare value is reached. Periodic channels reload automatically; one-shot channels disable themselves after firing.

## Interface

- `CHANNELS`, 4: number of alarm channels, legal range 1..8.
- `clk_i`  in  1: system clock, the same clock as the millisecond timer.
- `rstn_i`  in  1: reset, asynchronous assert, active-low.
- `time_i`  in  32: millisecond count from the timer.
- `tick_i`  in  1: one-ms event from the timer. High for exactly the cycle in which `time_i` increments at the next edge.
- `req_i`  in  1: bus request, one access per cycle.
- `we_i`  in  1: write enable, qualified by `req_i`.
- `addr_i`  in  5: word register index.
- `wdata_i`  in  32: write data.
- `ready_o`  out  1: access complete, one cycle after `req_i`.
- `rdata_o`  out  32: read data, valid while `ready_o` is high; 0 after writes.
- `irq_o`  out  1: level interrupt, equal to the OR of `PENDING[CHANNELS-1:0]`, driven from flops.

## Operation

- Register map, word index:
  - 0..7: `CMP[n]`, read/write.
  - 8..15: `PERIOD[n]`, read/write.
  - 16: `ENABLE`, read/write, bits [CHANNELS-1:0].
  - 17: `PENDING`, read; writing 1 clears the bit (W1C).
  - 18: `TIME`, read-only, returns `time_i`.
- Channel indices ≥ CHANNELS and unmapped indices read 0. Writes to them are ignored.
- `tick_q` is `tick_i` registered. In the cycle where `tick_q`=1, `time_i` already holds the new count.
- Fire condition for channel n: `tick_q` & `ENABLE[n]` & (`time_i` == `CMP[n]`). Equality only. A compare value already in the past does not fire until `time_i` wraps modulo 2^32.
- On fire:
  - `PENDING[n]` <= 1.
  - If `PERIOD[n]` != 0: `CMP[n]` <= `CMP[n]` + `PERIOD[n]`, 32-bit wrap-around.
  - Else: `ENABLE[n]` <= 0 (one-shot).
- Multiple channels may fire in the same cycle. Each channel is handled independently.
- Collision rules, same edge:
  - Bus write to `CMP[n]` and reload of channel n: bus value wins.
  - Bus write to `ENABLE` and one-shot auto-clear: bus value wins.
  - W1C of `PENDING[n]` and fire of channel n: set wins; the bit stays 1.
- Writing `ENABLE[n]`=1 does not modify `CMP[n]` or `PENDING[n]`.

## Timing

- Reset values: all `CMP`=0, all `PERIOD`=0, `ENABLE`=0, `PENDING`=0, `tick_q`=0, `ready_o`=0, `rdata_o`=0, `irq_o`=0. Reset asserted mid-access drops the access; `ready_o` is 0 out of reset.
- Bus timing:
  - Write data lands at the rising edge ending the `req_i` cycle.
  - `ready_o` is high exactly one cycle later.
  - A read returns the register value sampled at that edge, before any same-edge update.
  - Back-to-back requests every cycle are legal; `ready_o` stays high continuously.
- Alarm latency: `tick_i` high in cycle t → `tick_q` and new `time_i` in t+1 → `PENDING`, reload and auto-clear update at the end of t+1 → `irq_o` high in t+2.
- `irq_o` falls the cycle after the W1C edge that clears the last pending bit.
- A `CMP` write takes effect at the next `tick_q`, including a `tick_q` high in the cycle immediately after the write.

## Test plan

- Reset, then read indices 0..18 → every register reads 0, `TIME` reads `time_i`, `irq_o`=0.
- One-shot: `CMP[0]`=5, `PERIOD[0]`=0, `ENABLE`=1 at time 2 → `irq_o` rises 2 cycles after the tick that makes `time_i`=5, `ENABLE` reads 0, `PENDING` reads 1. Write `PENDING`=1 → `irq_o`=0 the next cycle.
- Periodic wrap: `CMP[1]`=0xFFFFFFFE, `PERIOD[1]`=4 → fires at 0xFFFFFFFE, `CMP[1]` reads 2, fires again at `time_i`=2.
- Collision: W1C of `PENDING[2]` on the same edge channel 2 fires → `PENDING[2]` stays 1. Separately, a bus write `CMP[2]`=100 on the reload edge → `CMP[2]` reads 100.
- Simultaneous fire: channels 0..3 all with `CMP`=10 → `PENDING`=0xF in one cycle. Periodic channels reload and one-shot channels disable in that same cycle.
- Past compare: `CMP[3]`=1 written while `time_i`=50 → no fire; `PENDING[3]` stays 0 over 100 ticks.

Source files
------------

// File: rtl/lsio_timer_alarm.sv
`default_nettype none
// ============================================================================
// Module      : lsio_timer_alarm
// Description : Multi-channel alarm scheduler driven by the low-speed-IO
//               millisecond timer. Each channel has a compare value, a reload
//               period and an enable bit. When the timer's count equals the
//               compare value on a tick, the channel's pending bit is set.
//               A non-zero period makes the channel periodic and advances the
//               compare value. A zero period makes it one-shot: the channel
//               clears its own enable.
// Ports       : clk_i    - system clock (shared with the ms timer)
//               rstn_i   - asynchronous active-low reset
//               time_i   - millisecond count from the timer
//               tick_i   - one-ms event; time_i increments at the next edge
//               req_i    - bus request (one access per cycle)
//               we_i     - bus write enable, qualified by req_i
//               addr_i   - word register index
//               wdata_i  - bus write data
//               ready_o  - access complete, one cycle after req_i
//               rdata_o  - read data while ready_o is high, 0 after writes
//               irq_o    - level interrupt, OR of the pending bits
// Register map: 0..7 CMP[n], 8..15 PERIOD[n], 16 ENABLE, 17 PENDING (W1C),
//               18 TIME (read-only)
// Revision    : 1.0 - initial release
// ============================================================================
module lsio_timer_alarm #(
  parameter int CHANNELS = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] time_i,
  input  logic        tick_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam logic [4:0] c_ADDR_PERIOD  = 5'd8;
  localparam logic [4:0] c_ADDR_ENABLE  = 5'd16;
  localparam logic [4:0] c_ADDR_PENDING = 5'd17;
  localparam logic [4:0] c_ADDR_TIME    = 5'd18;

  logic [31:0]         cmp_q    [CHANNELS];
  logic [31:0]         cmp_d    [CHANNELS];
  logic [31:0]         period_q [CHANNELS];
  logic [31:0]         period_d [CHANNELS];
  logic [CHANNELS-1:0] enable_q, enable_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic                tick_q;
  logic                ready_q;
  logic [31:0]         rdata_q;
  logic                irq_q;

  logic                w_wr;
  logic [CHANNELS-1:0] w_fire;
  logic [31:0]         w_rdata;

  assign w_wr = req_i & we_i;

  // Next-state logic. Ordering inside the block encodes the collision rules:
  // reload/auto-clear are applied first so a same-edge bus write overrides
  // them, while fire is OR-ed into PENDING last so it wins over W1C.
  always_comb begin
    cmp_d     = cmp_q;
    period_d  = period_q;
    enable_d  = enable_q;
    pending_d = pending_q;
    w_fire    = '0;

    for (int n = 0; n < CHANNELS; n++) begin
      // tick_q marks the first cycle in which time_i holds the new count.
      w_fire[n] = tick_q & enable_q[n] & (time_i == cmp_q[n]);
      if (w_fire[n]) begin
        if (period_q[n] != 32'd0) begin
          cmp_d[n] = cmp_q[n] + period_q[n];
        end else begin
          enable_d[n] = 1'b0;
        end
      end
      if (w_wr && (addr_i == 5'(n))) begin
        cmp_d[n] = wdata_i;
      end
      if (w_wr && (addr_i == c_ADDR_PERIOD + 5'(n))) begin
        period_d[n] = wdata_i;
      end
    end

    if (w_wr && (addr_i == c_ADDR_ENABLE)) begin
      enable_d = wdata_i[CHANNELS-1:0];
    end
    if (w_wr && (addr_i == c_ADDR_PENDING)) begin
      pending_d = pending_q & ~wdata_i[CHANNELS-1:0];
    end
    pending_d = pending_d | w_fire;
  end

  // Read mux over the current (pre-update) register values.
  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (addr_i == 5'(n)) begin
        w_rdata = cmp_q[n];
      end
      if (addr_i == c_ADDR_PERIOD + 5'(n)) begin
        w_rdata = period_q[n];
      end
    end
    if (addr_i == c_ADDR_ENABLE) begin
      w_rdata = 32'(enable_q);
    end
    if (addr_i == c_ADDR_PENDING) begin
      w_rdata = 32'(pending_q);
    end
    if (addr_i == c_ADDR_TIME) begin
      w_rdata = time_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int n = 0; n < CHANNELS; n++) begin
        cmp_q[n]    <= '0;
        period_q[n] <= '0;
      end
      enable_q  <= '0;
      pending_q <= '0;
      tick_q    <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      cmp_q     <= cmp_d;
      period_q  <= period_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      tick_q    <= tick_i;
      ready_q   <= req_i;
      rdata_q   <= (req_i && !we_i) ? w_rdata : 32'd0;
      // Registered from the next pending value so irq follows PENDING
      // without an extra cycle of delay.
      irq_q     <= |pending_d;
    end
  end

  assign ready_o = ready_q;
  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule
`default_nettype wire
